// File: rtl/label_pkg.sv
// label_pkg: label codes, config register addresses, default thresholds and
// configurator states shared by the label generator and label_cfg_ctrl.
package label_pkg;

    typedef enum logic [2:0] {
        LBL_ROAD  = 3'd0,
        LBL_WALK  = 3'd1,
        LBL_BG    = 3'd2,
        LBL_CAR   = 3'd3,
        LBL_HUMAN = 3'd4
    } label_t;

    localparam logic [1:0] CFG_ROAD_V = 2'd0;
    localparam logic [1:0] CFG_ROAD_S = 2'd1;
    localparam logic [1:0] CFG_WALK_V = 2'd2;
    localparam logic [1:0] CFG_WALK_S = 2'd3;

    localparam logic [7:0] DEF_ROAD_V = 8'd38;
    localparam logic [7:0] DEF_ROAD_S = 8'd77;
    localparam logic [7:0] DEF_WALK_V = 8'd179;
    localparam logic [7:0] DEF_WALK_S = 8'd51;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/label_frame_counter.sv
// label_frame_counter: saturating per-frame hit counter; the running count is
// published on frame_start and restarts, counting a hit on that same cycle.
module label_frame_counter #(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             hit,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] run;

    always_ff @(posedge clk) begin
        if (reset) begin
            run <= '0;
            cnt <= '0;
        end else if (frame_start) begin
            cnt <= run;
            run <= CNT_W'(hit);
        end else if (hit && run != '1) begin
            run <= run + CNT_W'(1);
        end
    end

endmodule

// File: rtl/label_cfg_ctrl.sv
// label_cfg_ctrl: shadow/live threshold configurator committing only at frame_start.
// Optional per-frame CAR/HUMAN pixel statistics under `LABEL_STATS_EN.
module label_cfg_ctrl
    import label_pkg::*;
#(
    parameter int TH_W  = 8,
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_addr,
    input  logic [TH_W-1:0]  cfg_wdata,
    input  logic             frame_start,
    input  logic             pixel_valid,
    input  logic [2:0]       label_data,
    output logic [TH_W-1:0]  road_v_th,
    output logic [TH_W-1:0]  road_s_th,
    output logic [TH_W-1:0]  walk_v_th,
    output logic [TH_W-1:0]  walk_s_th,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic [CNT_W-1:0] car_cnt,
    output logic [CNT_W-1:0] human_cnt
);

    localparam logic [TH_W-1:0] DEF [4] = '{TH_W'(DEF_ROAD_V), TH_W'(DEF_ROAD_S),
                                            TH_W'(DEF_WALK_V), TH_W'(DEF_WALK_S)};

    cfg_state_t      state, state_nx;
    logic [TH_W-1:0] shadow [4];
    logic [TH_W-1:0] live   [4];
    logic            wr;

    assign wr = cfg_valid && state != ST_COMMIT;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        cfg_ready   = state != ST_COMMIT;
        cfg_pending = state != ST_IDLE;
        state_nx    = state == ST_COMMIT  ? ST_IDLE :
                      state == ST_PENDING ? (frame_start ? ST_COMMIT : ST_PENDING) :
                      (wr ? ST_PENDING : ST_IDLE);
    end

    // A rejected commit rolls the shadow back so the next frame starts clean
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= DEF;
            live    <= DEF;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (wr) shadow[cfg_addr] <= cfg_wdata;
            if (state == ST_COMMIT) begin
                if (shadow[CFG_WALK_V] > shadow[CFG_ROAD_V]) begin
                    live <= shadow;
                end else begin
                    shadow  <= live;
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    assign road_v_th = live[CFG_ROAD_V];
    assign road_s_th = live[CFG_ROAD_S];
    assign walk_v_th = live[CFG_WALK_V];
    assign walk_s_th = live[CFG_WALK_S];

`ifdef LABEL_STATS_EN
    label_frame_counter #(.CNT_W(CNT_W)) u_car_cnt (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .hit         (pixel_valid && label_data == LBL_CAR),
        .cnt         (car_cnt)
    );

    label_frame_counter #(.CNT_W(CNT_W)) u_human_cnt (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .hit         (pixel_valid && label_data == LBL_HUMAN),
        .cnt         (human_cnt)
    );
`else
    logic unused_pixel;
    assign unused_pixel = ^{pixel_valid, label_data};
    assign car_cnt      = '0;
    assign human_cnt    = '0;
`endif

endmodule

// File: tb/tb_label_cfg_ctrl.sv
// tb_label_cfg_ctrl: scoreboard bench; a frame-level reference model queues the
// expected output vector per cycle and a negedge monitor compares it to the DUT.
module tb_label_cfg_ctrl;

    localparam int TH_W  = 8;
    localparam int CNT_W = 19;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef LABEL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_addr = '0;
    logic [TH_W-1:0]  cfg_wdata = '0;
    logic             frame_start = 1'b0;
    logic             pixel_valid = 1'b0;
    logic [2:0]       label_data = '0;
    logic [TH_W-1:0]  road_v_th, road_s_th, walk_v_th, walk_s_th;
    logic             cfg_pending, cfg_err;
    logic [CNT_W-1:0] car_cnt, human_cnt;
    logic             s_fs = 1'b0;
    logic             s_hit = 1'b0;
    logic [3:0]       s_cnt;

    label_cfg_ctrl #(.TH_W(TH_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .label_data  (label_data),
        .road_v_th   (road_v_th),
        .road_s_th   (road_s_th),
        .walk_v_th   (walk_v_th),
        .walk_s_th   (walk_s_th),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .car_cnt     (car_cnt),
        .human_cnt   (human_cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run
    label_frame_counter #(.CNT_W(4)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .frame_start (s_fs),
        .hit         (s_hit),
        .cnt         (s_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [95:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic void chk(string name, logic [95:0] got, logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("outputs", 96'({road_v_th, road_s_th, walk_v_th, walk_s_th,
                                cfg_ready, cfg_pending, cfg_err, car_cnt, human_cnt}), mon_e.v);
        end
    end

    // Reference model: frame-level view of shadow/live tables and stats
    int m_sh [4];
    int m_lv [4];
    bit m_pend, m_due, m_err;
    int m_car_run, m_hum_run, m_car, m_hum;

    task automatic tick(input bit rst, input bit v, input int a, input int d,
                        input bit fs, input bit pv, input int lab);
        bit   acc;
        int   hc, hh;
        exp_t e;
        reset = rst; cfg_valid = v; cfg_addr = 2'(a); cfg_wdata = TH_W'(d);
        frame_start = fs; pixel_valid = pv; label_data = 3'(lab);
        hc = (pv && lab == 3) ? 1 : 0;
        hh = (pv && lab == 4) ? 1 : 0;
        if (rst) begin
            m_sh = '{38, 77, 179, 51};
            m_lv = m_sh;
            m_pend = 0; m_due = 0; m_err = 0;
            m_car_run = 0; m_hum_run = 0; m_car = 0; m_hum = 0;
        end else begin
            acc = v && !m_due;
            m_err = 0;
            if (m_due) begin
                if (m_sh[2] > m_sh[0]) m_lv = m_sh;
                else begin
                    m_sh = m_lv;
                    m_err = 1;
                end
                m_due = 0;
                m_pend = 0;
            end else begin
                if (acc) m_sh[a] = d;
                if (m_pend && fs) m_due = 1;
                else if (acc) m_pend = 1;
            end
            if (fs) begin
                m_car = m_car_run; m_hum = m_hum_run;
                m_car_run = hc; m_hum_run = hh;
            end else begin
                m_car_run += hc; m_hum_run += hh;
            end
        end
        e.cyc = cyc + 1;
        e.v = 96'({TH_W'(m_lv[0]), TH_W'(m_lv[1]), TH_W'(m_lv[2]), TH_W'(m_lv[3]),
                   !m_due, m_pend || m_due, m_err,
                   STATS ? CNT_W'(m_car > CMAX ? CMAX : m_car) : CNT_W'(0),
                   STATS ? CNT_W'(m_hum > CMAX ? CMAX : m_hum) : CNT_W'(0)});
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d, input bit fs);
        tick(0, 1, a, d, fs, 0, 0);
    endtask

    initial begin
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Pending write held off for a long idle stretch, then committed
        wr(0, 50, 0);
        idle(1000);
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(4);
        // Rejected commit: WALK_V not above ROAD_V
        wr(0, 120, 0);
        wr(2, 100, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(4);
        // Write with frame_start joins the commit; write during COMMIT waits a cycle
        wr(1, 90, 0);
        wr(0, 60, 1);
        wr(3, 70, 0);
        wr(3, 70, 0);
        idle(3);
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // Reset while pending drops the write
        wr(0, 10, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // Stats frame: 1200 CAR + 300 HUMAN valid pixels, invalid CAR pixels mixed in
        tick(0, 0, 0, 0, 1, 1, 3);
        for (int i = 1; i < 1200; i++) tick(0, 0, 0, 0, 0, 1, 3);
        for (int i = 0; i < 300; i++) begin
            tick(0, 0, 0, 0, 0, 1, 4);
            tick(0, 0, 0, 0, 0, 0, 3);
            tick(0, 0, 0, 0, 0, 1, 2);
        end
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            tick(0, $urandom_range(0, 9) < 3, $urandom_range(0, 3), $urandom_range(0, 255),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7));
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(4);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        // Saturation of the narrow counter: 20 hits into 4 bits
        s_hit = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        s_fs = 1'b1;
        @(posedge clk); #1;
        s_fs = 1'b0;
        chk("sat_cnt", 96'(s_cnt), 96'(15));
        repeat (3) begin @(posedge clk); #1; end
        s_fs = 1'b1;
        @(posedge clk); #1;
        s_fs = 1'b0;
        s_hit = 1'b0;
        chk("restart_cnt", 96'(s_cnt), 96'(4));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
